ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit for the EX stage. It executes MULT/MULTU/DIV/DIVU in word (32-bit, sign-extended results) and doubleword modes, and holds the architectural HI/LO registers. It performs one radix-2 step per cycle and asserts `busy` so the hazard unit stalls dependent MFHI/MFLO and later mul/div issue. It complements the single-cycle ALU/shifter datapath and is generalised over datapath width.

---
 rtl/ex_muldiv_unit_if.sv | 45 ++++
 rtl/ex_muldiv_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_unit_if.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit_if
// Groups the issue, MTHI/MTLO and result signals of the EX-stage
// multiply/divide unit. The EX stage drives through 'master'; the unit
// itself connects through 'slave'.
//
//   start       request a new operation (accepted only when idle)
//   op          0 MULT, 1 MULTU, 2 DIV, 3 DIVU
//   word        1 = operate on the low WIDTH/2 bits, results sign-extended
//   a, b        forwarded operands
//   flush       cancel any in-flight operation
//   wr_hi/wr_lo MTHI/MTLO strobes, data on wr_data
//   busy        unit not idle (stall dependent MFHI/MFLO and mul/div)
//   done        one-cycle completion pulse
//   div_by_zero qualifies done for a divide with zero divisor
//   hi, lo      architectural HI/LO registers
// ---------------------------------------------------------------------------
interface ex_muldiv_unit_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [1:0]       op;
  logic             word;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             wr_hi;
  logic             wr_lo;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, word, a, b, flush, wr_hi, wr_lo, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, word, a, b, flush, wr_hi, wr_lo, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// ex_muldiv_unit
// Iterative radix-2 multiply/divide unit for the EX stage, holding HI/LO.
// Operands are reduced to magnitudes at issue, N = WIDTH or WIDTH/2 steps
// are run (shift-add multiply or restoring divide), and the signs are
// applied in a final FIX cycle that also writes HI/LO and pulses done.
//
//   clock  rising-edge clock
//   reset  asynchronous, active-high
//   bus    ex_muldiv_unit_if.slave (issue, MTHI/MTLO, status, HI/LO)
// ---------------------------------------------------------------------------
module ex_muldiv_unit #(
  parameter int WIDTH = 64
) (
  input logic            clock,
  input logic            reset,
  ex_muldiv_unit_if.slave bus
);
  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               word_q, word_d;
  logic               neg_lo_q, neg_lo_d;     // negate product / quotient
  logic               neg_hi_q, neg_hi_d;     // negate remainder (div only)
  logic               dbz_flag_q, dbz_flag_d;
  // Multiply: running product. Divide: {remainder, dividend -> quotient}.
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;       // multiplicand, shifts left
  logic [WIDTH-1:0]   opb_q, opb_d;           // multiplier (shifts right) or divisor
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;
  logic               busy;

  // Issue-time operand decode
  logic               signed_op, op_is_div, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;

  // Step and result datapath
  logic [WIDTH:0]     rem_shift, rem_sub;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix, res_hi, res_lo;

  function automatic logic [WIDTH-1:0] sext_half(input logic [WIDTH-1:0] v);
    return {{HALF{v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  // Magnitude of an operand at the active width, zero-extended to WIDTH.
  function automatic logic [WIDTH-1:0] active_mag(input logic [WIDTH-1:0] v,
                                                  input logic wd,
                                                  input logic neg);
    logic [WIDTH-1:0] act;
    act = wd ? {{HALF{1'b0}}, v[HALF-1:0]} : v;
    if (neg) begin
      act = -act;
      if (wd) act[WIDTH-1:HALF] = '0;
    end
    return act;
  endfunction

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.start && !bus.flush) state_d = S_RUN;
      S_RUN:   if (bus.flush) state_d = S_IDLE;
               else if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy   = (state_q != S_IDLE);
    done_d = (state_q == S_FIX) && !bus.flush;
    dbz_d  = done_d && dbz_flag_q;
  end

  // -------------------------------------------------------------------------
  // Operand decode at issue
  // -------------------------------------------------------------------------
  always_comb begin
    signed_op = ~bus.op[0];
    op_is_div = bus.op[1];
    sign_a    = signed_op & (bus.word ? bus.a[HALF-1] : bus.a[WIDTH-1]);
    sign_b    = signed_op & (bus.word ? bus.b[HALF-1] : bus.b[WIDTH-1]);
    mag_a     = active_mag(bus.a, bus.word, sign_a);
    mag_b     = active_mag(bus.b, bus.word, sign_b);
  end

  // -------------------------------------------------------------------------
  // Iteration datapath
  // -------------------------------------------------------------------------
  always_comb begin
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    opb_d      = opb_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    word_d     = word_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    dbz_flag_d = dbz_flag_q;

    // Restoring step: shift the next dividend bit into the remainder and
    // subtract; no borrow out of bit WIDTH means the quotient bit is 1.
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_sub   = rem_shift - {1'b0, opb_q};
    q_bit     = ~rem_sub[WIDTH];

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          is_div_d   = op_is_div;
          word_d     = bus.word;
          neg_lo_d   = sign_a ^ sign_b;
          // Remainder follows the dividend; a product takes the joint sign.
          neg_hi_d   = op_is_div ? sign_a : (sign_a ^ sign_b);
          dbz_flag_d = op_is_div && (mag_b == '0);
          cnt_d      = bus.word ? CW'(HALF) : CW'(WIDTH);
          opb_d      = mag_b;
          if (op_is_div) begin
            // Left-align a word dividend so its MSB is consumed first.
            acc_d   = {{WIDTH{1'b0}}, (bus.word ? (mag_a << HALF) : mag_a)};
            mcand_d = '0;
          end else begin
            acc_d   = '0;
            mcand_d = {{WIDTH{1'b0}}, mag_a};
          end
        end
      end
      S_RUN: begin
        if (!bus.flush) begin
          cnt_d = cnt_q - CW'(1);
          if (is_div_q) begin
            acc_d = {(q_bit ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], q_bit};
          end else begin
            if (opb_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = mcand_q << 1;
            opb_d   = opb_q >> 1;
          end
        end
      end
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sign correction and result formatting
  // -------------------------------------------------------------------------
  always_comb begin
    prod_fix = neg_lo_q ? -acc_q : acc_q;
    quot_fix = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    if (is_div_q) begin
      // With a zero divisor the remainder already equals |dividend|, so the
      // sign correction above restores the dividend; only LO needs forcing.
      res_lo = dbz_flag_q ? '1 : quot_fix;
      res_hi = rem_fix;
    end else if (word_q) begin
      res_lo = prod_fix[WIDTH-1:0];
      res_hi = {{HALF{1'b0}}, prod_fix[WIDTH-1:HALF]};
    end else begin
      res_lo = prod_fix[WIDTH-1:0];
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
    end

    if (word_q) begin
      res_lo = sext_half(res_lo);
      res_hi = sext_half(res_hi);
    end
  end

  // HI/LO: MTHI/MTLO only while idle; a completing operation wins later.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == S_IDLE) begin
      if (bus.wr_hi) hi_d = bus.wr_data;
      if (bus.wr_lo) lo_d = bus.wr_data;
    end else if ((state_q == S_FIX) && !bus.flush) begin
      hi_d = res_hi;
      lo_d = res_lo;
    end
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      word_q     <= 1'b0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      dbz_flag_q <= 1'b0;
      acc_q      <= '0;
      mcand_q    <= '0;
      opb_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      word_q     <= word_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      dbz_flag_q <= dbz_flag_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      opb_q      <= opb_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_muldiv_unit
// Directed vectors with hand-computed HI/LO for ex_muldiv_unit (WIDTH=64),
// plus sequences for MTHI/MTLO, flush, ignored start, back-to-back issue
// and asynchronous reset. Inputs change and outputs are sampled on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_ex_muldiv_unit;
  localparam int W       = 64;
  localparam int TIMEOUT = 200;

  logic clock = 1'b0;
  logic reset;

  ex_muldiv_unit_if #(.WIDTH(W)) bus ();

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [1:0]   op;
    logic         word;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dbz;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Called at a falling edge; start is seen by the next rising edge (E0)
  // and the task returns at the falling edge right after E0.
  task automatic issue(input logic [1:0] op, input logic word,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op    = op;
    bus.word  = word;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask

  // Starting at the sample after E0, counts edges until done is seen and
  // the samples with busy high. Bounded by TIMEOUT.
  task automatic wait_done(output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = bus.busy ? 1 : 0;
    while (!bus.done && edges < TIMEOUT) begin
      @(negedge clock);
      edges++;
      if (bus.busy) busy_cnt++;
    end
    if (!bus.done) begin
      tests_run++;
      tests_failed++;
      $display("FAIL done_timeout: no done within %0d cycles", TIMEOUT);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int edges, busy_cnt, done_seen, busy_seen;

    vecs[0]  = '{2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0};
    vecs[1]  = '{2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,
                 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[2]  = '{2'd2, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vecs[3]  = '{2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'd0, 64'h8000_0000_0000_0000, 1'b0};
    vecs[4]  = '{2'd3, 1'b0, 64'h1234, 64'd0,
                 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[5]  = '{2'd1, 1'b1, 64'hDEAD_0000_FFFF_FFFF, 64'h1234_5678_0000_0002,
                 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[6]  = '{2'd2, 1'b1, 64'd7, 64'h0000_0000_FFFF_FFFE,
                 64'd1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
    vecs[7]  = '{2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                 64'd0, 64'hFFFF_FFFF_8000_0000, 1'b0};
    vecs[8]  = '{2'd2, 1'b1, 64'h0000_0000_FFFF_FFFB, 64'd0,
                 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[9]  = '{2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 64'd0, 64'd1, 1'b0};
    vecs[10] = '{2'd3, 1'b0, 64'd100, 64'd7, 64'd2, 64'd14, 1'b0};
    vecs[11] = '{2'd0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
                 64'h3FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0};
    vecs[12] = '{2'd3, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h10,
                 64'hF, 64'h0000_0000_0FFF_FFFF, 1'b0};
    vecs[13] = '{2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7,
                 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, 1'b0};

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = 2'd0;
    bus.word    = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.flush   = 1'b0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    bus.wr_data = '0;

    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Reset state
    check("reset_hi",   bus.hi, '0);
    check("reset_lo",   bus.lo, '0);
    check("reset_busy", W'(bus.busy), '0);
    check("reset_done", W'(bus.done), '0);
    check("reset_dbz",  W'(bus.div_by_zero), '0);

    // Table-driven operations
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b);
      wait_done(edges, busy_cnt);
      check($sformatf("v%0d_latency", i), W'(edges), vecs[i].word ? W'(33) : W'(65));
      check($sformatf("v%0d_busy_cycles", i), W'(busy_cnt), vecs[i].word ? W'(33) : W'(65));
      check($sformatf("v%0d_hi", i), bus.hi, vecs[i].exp_hi);
      check($sformatf("v%0d_lo", i), bus.lo, vecs[i].exp_lo);
      check($sformatf("v%0d_dbz", i), W'(bus.div_by_zero), W'(vecs[i].exp_dbz));
      check($sformatf("v%0d_busy_at_done", i), W'(bus.busy), '0);
      @(negedge clock);
      check($sformatf("v%0d_done_pulse", i), W'(bus.done), '0);
      check($sformatf("v%0d_dbz_pulse", i), W'(bus.div_by_zero), '0);
    end

    // MTHI/MTLO, then DIVU 100/7 with a stray start and a flush mid-RUN
    bus.wr_hi = 1'b1; bus.wr_data = 64'hAA;
    @(negedge clock);
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wr_data = 64'h55;
    @(negedge clock);
    bus.wr_lo = 1'b0;
    check("mthi", bus.hi, 64'hAA);
    check("mtlo", bus.lo, 64'h55);
    issue(2'd3, 1'b0, 64'd100, 64'd7);
    check("flush_seq_busy", W'(bus.busy), 64'd1);
    repeat (4) @(negedge clock);
    issue(2'd1, 1'b1, 64'd5, 64'd5);            // ignored: unit is busy
    check("stray_start_busy", W'(bus.busy), 64'd1);
    repeat (4) @(negedge clock);
    bus.flush = 1'b1;                            // seen at RUN edge 10
    @(negedge clock);
    bus.flush = 1'b0;
    check("flush_busy_drop", W'(bus.busy), '0);
    check("flush_no_done", W'(bus.done), '0);
    done_seen = 0;
    busy_seen = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      if (bus.done) done_seen++;
      if (bus.busy) busy_seen++;
    end
    check("flush_done_never", W'(done_seen), '0);
    check("flush_stays_idle", W'(busy_seen), '0);
    check("flush_hi_kept", bus.hi, 64'hAA);
    check("flush_lo_kept", bus.lo, 64'h55);
    check("flush_dbz", W'(bus.div_by_zero), '0);

    // Flush in IDLE suppresses start
    bus.flush = 1'b1;
    issue(2'd0, 1'b0, 64'd3, 64'd3);
    bus.flush = 1'b0;
    check("idle_flush_blocks_start", W'(bus.busy), '0);

    // MTHI in the same cycle as an accepted start, then back-to-back issue
    bus.wr_hi = 1'b1; bus.wr_data = 64'h1111;
    issue(2'd1, 1'b1, 64'd6, 64'd7);
    bus.wr_hi = 1'b0;
    check("same_cycle_mthi", bus.hi, 64'h1111);
    wait_done(edges, busy_cnt);
    check("b2b_first_hi", bus.hi, 64'd0);
    check("b2b_first_lo", bus.lo, 64'd42);
    issue(2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3);   // during done
    check("b2b_accepted", W'(bus.busy), 64'd1);
    wait_done(edges, busy_cnt);
    check("b2b_latency", W'(edges), 64'd33);
    check("b2b_hi", bus.hi, 64'hFFFF_FFFF_FFFF_FFFF);
    check("b2b_lo", bus.lo, 64'hFFFF_FFFF_FFFF_FFFA);
    @(negedge clock);

    // Asynchronous reset mid-RUN
    issue(2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    repeat (20) @(negedge clock);
    reset = 1'b1;
    #1;
    check("async_reset_busy", W'(bus.busy), '0);
    check("async_reset_hi", bus.hi, '0);
    check("async_reset_lo", bus.lo, '0);
    check("async_reset_done", W'(bus.done), '0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    issue(2'd3, 1'b1, 64'd9, 64'd4);
    wait_done(edges, busy_cnt);
    check("post_reset_hi", bus.hi, 64'd1);
    check("post_reset_lo", bus.lo, 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
